// File: rtl/mp_arith_pkg.sv
// Shared helpers for the iterative multi-precision adder/subtractor.
// Limb-count math and the controller state encoding.
package mp_arith_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  function automatic int num_limbs(input int w, input int l);
    return (w + l - 1) / l;
  endfunction

endpackage

// File: rtl/mp_limb_adder.sv
// One limb of the multi-precision add: W-bit sum with carry in/out.
// Purely combinational; the top reuses it for every limb.
module mp_limb_adder #(
  parameter int W = 128
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Single ripple-free add; synthesis picks the carry structure.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mp_addsub_iter.sv
// Iterative A+B / A-B, one LIMB_W-bit limb per cycle, registered carry.
// Optional zero flag enabled by defining MPADD_ZERO_FLAG_EN.
module mp_addsub_iter
  import mp_arith_pkg::*;
#(
  parameter int WIDTH  = 1027,
  parameter int LIMB_W = 128
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic             done
`ifdef MPADD_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NUM_LIMBS = num_limbs(WIDTH, LIMB_W);
  localparam int PAD_W     = NUM_LIMBS * LIMB_W;
  localparam int LAST_W    = WIDTH - (NUM_LIMBS - 1) * LIMB_W;
  localparam int IDX_W     = (NUM_LIMBS > 1) ? clog2(NUM_LIMBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               sub_q;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [PAD_W-1:0]   a_pad;
  logic [PAD_W-1:0]   b_pad;
  logic [31:0]        base;
  logic [LIMB_W-1:0]  a_limb;
  logic [LIMB_W-1:0]  b_limb;
  logic [LIMB_W-1:0]  sum;
  logic               cout;
  logic [LIMB_W:0]    full;
  logic               last;
  logic               top_c;

  // Pad bits are zero so the carry out of bit WIDTH-1 lands at LAST_W.
  assign a_pad  = PAD_W'(op_a);
  assign b_pad  = PAD_W'(op_b);
  assign base   = 32'(idx) * 32'(LIMB_W);
  assign a_limb = a_pad[base +: LIMB_W];
  assign b_limb = b_pad[base +: LIMB_W];
  assign full   = {cout, sum};
  assign last   = (idx == LAST_IDX);
  assign top_c  = full[LAST_W];

  mp_limb_adder #(
    .W(LIMB_W)
  ) u_limb (
    .a   (a_limb),
    .b   (b_limb),
    .cin (carry),
    .sum (sum),
    .cout(cout)
  );

  // Controller: capture operands, walk limbs, write result, pulse done.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a  <= in_a;
            op_b  <= in_b ^ {WIDTH{subtract}};
            sub_q <= subtract;
            carry <= subtract;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (idx == IDX_W'(i / LIMB_W))
              result[i] <= sum[i % LIMB_W];
          end
          carry <= cout;
          idx   <= idx + 1'b1;
          if (last) begin
            result[WIDTH] <= top_c ^ sub_q;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MPADD_ZERO_FLAG_EN
  localparam logic [LIMB_W-1:0] LAST_MASK =
    {LIMB_W{1'b1}} >> (LIMB_W - LAST_W);

  logic [LIMB_W-1:0] live_mask;
  logic              limb_zero;
  logic              zacc;

  assign live_mask = last ? LAST_MASK : {LIMB_W{1'b1}};
  assign limb_zero = ((sum & live_mask) == '0);

  // AND together per-limb zero tests; publish alongside done.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      zacc <= 1'b1;
      zero <= 1'b0;
    end else if (state == IDLE) begin
      if (start) zacc <= 1'b1;
    end else begin
      zacc <= zacc & limb_zero;
      if (last) zero <= zacc & limb_zero;
    end
  end
`endif

endmodule
